// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse train scheduler.
// Holds the FSM state encoding and the effective-period rule.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A zero period behaves like a period of one clock.
  function automatic int unsigned eff_period(
    input int unsigned ticks
  );
    return (ticks == 0) ? 1 : ticks;
  endfunction

endpackage

// File: rtl/pulse_train_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr.
// Purely combinational; grant is valid only when any req is set.
module rr_arbiter #(
  parameter int M = 4
) (
  input  logic [M-1:0]         req,
  input  logic [$clog2(M)-1:0] ptr,
  output logic [M-1:0]         grant,
  output logic [$clog2(M)-1:0] grant_id
);

  localparam int W = $clog2(M);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < M; k++) begin
      idx = W'((int'(ptr) + k) % M);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/pulse_train_scheduler.sv
// Shares one period timer among M requesters.
// Grants round-robin and runs each pulse train to completion.
module pulse_train_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int C = 8,
  parameter int M = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M-1:0]         req,
  input  logic [M-1:0][N-1:0]  req_ticks,
  input  logic [M-1:0][C-1:0]  req_count,
  input  logic                 abort,
  output logic [M-1:0]         gnt,
  output logic                 busy,
  output logic                 out,
  output logic [$clog2(M)-1:0] out_id,
  output logic [M-1:0]         done
);

  localparam int W = $clog2(M);

  state_e       state;
  state_e       state_nx;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nx;
  logic [N-1:0] ticks_q;
  logic [N-1:0] timer;
  logic [N-1:0] period;
  logic [C-1:0] cnt;
  logic [M-1:0] arb_gnt;
  logic [W-1:0] arb_id;
  logic [M-1:0] owner_oh;
  logic         any_req;
  logic         hit;

  rr_arbiter #(
    .M(M)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .grant   (arb_gnt),
    .grant_id(arb_id)
  );

  assign any_req  = |req;
  assign period   = N'(eff_period(32'(ticks_q)));
  assign owner_oh = {{(M-1){1'b0}}, 1'b1} << out_id;
  assign ptr_nx   = (arb_id == W'(M - 1)) ?
                    '0 : arb_id + 1'b1;

  // An abort in the hit cycle suppresses that pulse.
  assign hit = (state == RUN) && (cnt != '0) &&
               (timer == period - N'(1)) && !abort;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any_req) state_nx = RUN;
      RUN: begin
        if (abort)
          state_nx = IDLE;
        else if (cnt == '0)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      ticks_q <= '0;
      timer   <= '0;
      cnt     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      out     <= 1'b0;
      out_id  <= '0;
      done    <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      gnt   <= '0;
      done  <= '0;
      out   <= hit;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            ticks_q <= req_ticks[arb_id];
            cnt     <= req_count[arb_id];
            out_id  <= arb_id;
            ptr     <= ptr_nx;
            gnt     <= arb_gnt;
            timer   <= '0;
          end
        end
        RUN: begin
          if (hit) begin
            timer <= '0;
            cnt   <= cnt - 1'b1;
          end else if (cnt != '0) begin
            timer <= timer + 1'b1;
          end
          if (!abort && cnt == '0)
            done <= owner_oh;
        end
        default: begin
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_train_scheduler.md
# pulse_train_scheduler

Shares one period timer among `M` requesters. Each requester asks for a train of `count` single-cycle pulses spaced `ticks` clocks apart. A round-robin arbiter grants one requester at a time, and the scheduler runs that train to completion or abort before it services the next requester. It sits between multiple rate-limited clients (packet pacers, retry timers) and the single pacing resource they would otherwise duplicate.

## Interface
Parameters:
- `N`, 8: width of the period (`ticks`) field.
- `C`, 8: width of the pulse-count field.
- `M`, 4: number of requesters (≥2).

Ports:
- `clk`  in  1  — single clock, all logic on its rising edge.
- `rst`  in  1  — reset, asynchronous, active-low.
- `req`  in  M  — request per requester; level, held until `gnt`.
- `req_ticks`  in  M×N (packed `[M-1:0][N-1:0]`)  — period per requester, stable while `req` is high.
- `req_count`  in  M×C (packed `[M-1:0][C-1:0]`)  — pulse count per requester, stable while `req` is high.
- `abort`  in  1  — cancel the active train.
- `gnt`  out  M  — one-hot, one-cycle grant; marks the request as accepted.
- `busy`  out  1  — a train is active (state ≠ IDLE).
- `out`  out  1  — pacing pulse, one cycle wide.
- `out_id`  out  $clog2(M)  — owner of the current or last train.
- `done`  out  M  — one-cycle completion strobe for the owner.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**:
  - If any `req` bit is set, pick the winner `i` round-robin, starting the search at pointer `ptr`.
  - Latch `req_ticks[i]` and `req_count[i]`, set `out_id=i` and `ptr=(i+1) mod M`.
  - Next cycle: `gnt[i]=1` and the state is RUN.
- **RUN**:
  - Effective period is `P = max(ticks,1)`.
  - The timer clears on RUN entry and increments each cycle.
  - When the timer reaches `P-1`: pulse `out` (registered, visible the next cycle), decrement the remaining count, and clear the timer.
  - When the remaining count reaches 0, go to DONE.
  - If the latched count is 0, RUN goes to DONE after one cycle with no pulses.
- **DONE**: `done[out_id]=1` for one cycle, then IDLE.
- **abort** in RUN: the next state is IDLE and `done` is not asserted.
  - A pulse already registered in the abort cycle is still emitted; no later pulses are emitted.
  - `abort` in IDLE or DONE is ignored.
- Requester obligations:
  - Drop `req` in the cycle after `gnt`; a `req` still high in IDLE counts as a new request.
  - Dropping `req` before `gnt` withdraws the request.
  - `req` of the active owner is ignored while `busy`.
- Arithmetic:
  - Timer is N bits and the count is C bits, both unsigned.
  - No wrap is possible: the timer never exceeds `P-1` and the count never decrements below 0.

## Timing
- Reset values: state IDLE, `gnt=0`, `done=0`, `out=0`, `out_id=0`, `busy=0`, `ptr=0`, timer 0, count 0.
- A reset assertion mid-train returns to IDLE immediately. No `done` is issued and the train is lost.
- Grant latency: `req` sampled in IDLE at cycle t gives `gnt` and `busy` at t+1.
- First `out` at t+1+P; subsequent pulses every P cycles.
- `done` one cycle after the last `out`; IDLE the cycle after `done`.
- Earliest next grant is at `done`+2.
- `busy` is high from the `gnt` cycle through the `done` cycle inclusive.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `pulse_sched_pkg` holds the state enum (IDLE, RUN, DONE) and the `P = max(ticks,1)` helper function.
- One sub-module, `rr_arbiter`:
  - Parameter M.
  - Inputs `req[M]` and `ptr`.
  - Combinational outputs: one-hot `grant` and encoded `grant_id`.
  - `grant` is valid only when any `req` bit is set.
- The pointer register stays in the scheduler.

## Test plan
- **Single train:** `req[1]` with `ticks=3`, `count=2`, in IDLE at cycle 0 → `gnt=4'b0010` at 1; `out` at 4 and 7 with `out_id=1`; `done=4'b0010` at 8; `busy` low at 9.
- **Degenerate periods:** `ticks=0` and `ticks=1`, `count=3` → `out` on three consecutive cycles starting at `gnt`+1. Separately, `count=0` → `done` at `gnt`+1 and `out` never asserted.
- **Fairness:** all four `req` held continuously, each re-raised after its `done` → grant order 0,1,2,3,0. Each requester receives exactly its own count of pulses with the matching `out_id`.
- **Abort:** `ticks=4`, `count=5`, `abort` pulsed after the second `out` → no further `out`, no `done`, `busy` low the next cycle. The next pending requester is granted one cycle later.
- **Reset mid-train:** `rst` low during RUN → all outputs at reset values asynchronously. After release, a fresh request starts from requester 0 priority.
- **Request withdrawal:** `req[2]` raised then dropped before `gnt` while another train runs → no `gnt[2]` and no pulses for id 2.
